schmidl_cox_frame_ctrl: RTL and testbench

Frame-synchronisation controller for the Schmidl-Cox receive chain. It consumes the averaged metric stream and the latency-aligned sample stream of the metric calculator in lockstep. It searches for a metric peak above a programmable threshold, then gates exactly one frame of samples to the downstream OFDM demodulator, starting at a fixed offset from the peak. All samples outside a frame are consumed and discarded, so the metric calculator never stalls.

---
 rtl/schmidl_cox_pkg.sv | 22 ++
 rtl/sc_peak_tracker.sv | 53 +++++
 rtl/schmidl_cox_frame_ctrl.sv | 172 +++++++++++++++++
 tb/tb_schmidl_cox_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/schmidl_cox_pkg.sv
// Shared types and sizing helpers for the Schmidl-Cox frame-synchronisation controller.
package schmidl_cox_pkg;

  typedef enum logic [1:0] {SEARCH, PEAK, SKIP, OUTPUT} sc_ctrl_state_t;

  localparam int NUM_SYMBOLS_W = 8;
  localparam int FRAME_COUNT_W = 16;

  function automatic int metric_width(input int cp_size);
    return 32 + $clog2(cp_size + 1);
  endfunction

  function automatic int symbol_len(input int fft_size, input int cp_size);
    return fft_size + cp_size;
  endfunction

  // Wide enough for the longest frame: 255 symbols of FFT+CP samples.
  function automatic int out_cnt_width(input int fft_size, input int cp_size);
    return NUM_SYMBOLS_W + $clog2(fft_size + cp_size);
  endfunction

endpackage

// File: rtl/sc_peak_tracker.sv
// Tracks the running metric maximum over the peak-search window; ties keep the earliest peak.
module sc_peak_tracker #(
  parameter int MW          = 35,
  parameter int PEAK_WINDOW = 128,
  localparam int IW         = $clog2(PEAK_WINDOW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          start,
  input  logic          beat,
  input  logic [MW-1:0] metric,
  output logic          done,
  output logic [IW-1:0] peak_idx
);

  logic [MW-1:0] peak_val_q;
  logic [IW-1:0] peak_idx_q;
  logic [IW-1:0] win_cnt_q;
  logic [IW-1:0] win_inc;
  logic          higher;

  always_comb begin
    higher   = metric > peak_val_q;
    win_inc  = win_cnt_q + IW'(1);
    done     = beat && (win_inc == IW'(PEAK_WINDOW));
    // Include the current beat so the completing beat can still become the peak.
    peak_idx = (beat && higher) ? win_cnt_q : peak_idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_val_q <= '0;
      peak_idx_q <= '0;
      win_cnt_q  <= '0;
    end else if (clear) begin
      peak_val_q <= '0;
      peak_idx_q <= '0;
      win_cnt_q  <= '0;
    end else if (start) begin
      peak_val_q <= metric;
      peak_idx_q <= '0;
      win_cnt_q  <= IW'(1);
    end else if (beat) begin
      win_cnt_q <= win_inc;
      if (higher) begin
        peak_val_q <= metric;
        peak_idx_q <= win_cnt_q;
      end
    end
  end

endmodule

// File: rtl/schmidl_cox_frame_ctrl.sv
// Schmidl-Cox frame controller: finds the metric peak, then gates one frame of samples out.
// Define SCHMIDL_COX_FRAME_COUNT_EN to build the completed-frame counter.
module schmidl_cox_frame_ctrl
  import schmidl_cox_pkg::*;
#(
  parameter int FFT_SIZE     = 1024,
  parameter int CP_SIZE      = 128,
  parameter int MW           = metric_width(CP_SIZE),
  parameter int PEAK_WINDOW  = CP_SIZE,
  parameter int START_OFFSET = FFT_SIZE
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [MW-1:0] threshold,
  input  logic [7:0]    num_symbols,
  input  logic [MW-1:0] m_tdata,
  input  logic          m_tlast,
  input  logic          m_tvalid,
  output logic          m_tready,
  input  logic [31:0]   s_tdata,
  input  logic          s_tlast,
  input  logic          s_tvalid,
  output logic          s_tready,
  output logic [31:0]   o_tdata,
  output logic          o_tlast,
  output logic          o_tvalid,
  input  logic          o_tready,
  output logic          detect,
  output logic [15:0]   frame_count
);

  localparam int IW      = $clog2(PEAK_WINDOW + 1);
  localparam int SW      = $clog2(START_OFFSET + 1);
  localparam int OW      = out_cnt_width(FFT_SIZE, CP_SIZE);
  localparam int SYM_LEN = symbol_len(FFT_SIZE, CP_SIZE);

  if (START_OFFSET <= PEAK_WINDOW) begin : g_bad_offset
    $error("START_OFFSET must be greater than PEAK_WINDOW");
  end

  sc_ctrl_state_t state_q, state_d;
  logic [7:0]    nsym_q, nsym_d, nsym_eff;
  logic [SW-1:0] skip_q, skip_d;
  logic [OW-1:0] out_q, out_d, frame_len, last_idx;
  logic          detect_q, detect_d;
  logic          join_ok, in_ready, beat, start, pt_beat, pt_done, out_last, frame_done;
  logic [IW-1:0] pk_idx;
  logic          unused_tlast;

  assign unused_tlast = ^{m_tlast, s_tlast};

  sc_peak_tracker #(
    .MW          (MW),
    .PEAK_WINDOW (PEAK_WINDOW)
  ) u_peak (
    .clk      (clk),
    .rst      (reset),
    .clear    (clear),
    .start    (start),
    .beat     (pt_beat),
    .metric   (m_tdata),
    .done     (pt_done),
    .peak_idx (pk_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SEARCH;
      nsym_q   <= '0;
      skip_q   <= '0;
      out_q    <= '0;
      detect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      nsym_q   <= nsym_d;
      skip_q   <= skip_d;
      out_q    <= out_d;
      detect_q <= detect_d;
    end
  end

  always_comb begin
    join_ok    = m_tvalid & s_tvalid;
    in_ready   = (state_q == OUTPUT) ? (o_tready & join_ok) : 1'b1;
    beat       = join_ok & in_ready;
    start      = (state_q == SEARCH) & beat & (m_tdata > threshold) & ~clear;
    pt_beat    = (state_q == PEAK) & beat & ~clear;
    nsym_eff   = (nsym_q == 8'd0) ? 8'd1 : nsym_q;
    frame_len  = OW'(nsym_eff) * OW'(SYM_LEN);
    last_idx   = frame_len - OW'(1);
    out_last   = (out_q == last_idx);
    frame_done = (state_q == OUTPUT) & beat & out_last & ~clear;

    m_tready = in_ready;
    s_tready = in_ready;
    o_tdata  = s_tdata;
    o_tvalid = join_ok & (state_q == OUTPUT);
    o_tlast  = o_tvalid & out_last;
    detect   = detect_q;

    state_d  = state_q;
    nsym_d   = nsym_q;
    skip_d   = skip_q;
    out_d    = out_q;
    detect_d = 1'b0;

    unique case (state_q)
      SEARCH: begin
        if (start) begin
          nsym_d  = num_symbols;
          state_d = PEAK;
        end
      end
      PEAK: begin
        if (pt_done) begin
          skip_d   = SW'(START_OFFSET - PEAK_WINDOW) + SW'(pk_idx);
          detect_d = 1'b1;
          state_d  = SKIP;
        end
      end
      SKIP: begin
        if (beat) begin
          skip_d = skip_q - SW'(1);
          if (skip_q == SW'(1)) begin
            out_d   = '0;
            state_d = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        if (beat) begin
          if (out_last) begin
            out_d   = '0;
            state_d = SEARCH;
          end else begin
            out_d = out_q + OW'(1);
          end
        end
      end
      default: state_d = SEARCH;
    endcase

    if (clear) begin
      state_d  = SEARCH;
      skip_d   = '0;
      out_d    = '0;
      detect_d = 1'b0;
    end
  end

`ifdef SCHMIDL_COX_FRAME_COUNT_EN
  logic [FRAME_COUNT_W-1:0] fc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fc_q <= '0;
    end else if (clear) begin
      fc_q <= '0;
    end else if (frame_done) begin
      fc_q <= fc_q + FRAME_COUNT_W'(1);
    end
  end

  assign frame_count = fc_q;
`else
  logic unused_frame_done;
  assign unused_frame_done = frame_done;
  assign frame_count       = '0;
`endif

endmodule

// File: tb/tb_schmidl_cox_frame_ctrl.sv
// Directed self-checking bench for schmidl_cox_frame_ctrl with a small FFT/CP configuration.
module tb_schmidl_cox_frame_ctrl;
  import schmidl_cox_pkg::*;

  localparam int FFT = 16;
  localparam int CP  = 4;
  localparam int PW  = 4;
  localparam int SO  = 16;
  localparam int MW  = metric_width(CP);

  logic          clk = 1'b0;
  logic          reset, clear;
  logic [MW-1:0] threshold;
  logic [7:0]    num_symbols;
  logic [MW-1:0] m_tdata;
  logic          m_tlast, m_tvalid, m_tready;
  logic [31:0]   s_tdata;
  logic          s_tlast, s_tvalid, s_tready;
  logic [31:0]   o_tdata;
  logic          o_tlast, o_tvalid, o_tready;
  logic          detect;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  schmidl_cox_frame_ctrl #(
    .FFT_SIZE     (FFT),
    .CP_SIZE      (CP),
    .PEAK_WINDOW  (PW),
    .START_OFFSET (SO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .threshold   (threshold),
    .num_symbols (num_symbols),
    .m_tdata     (m_tdata),
    .m_tlast     (m_tlast),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .s_tdata     (s_tdata),
    .s_tlast     (s_tlast),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .o_tdata     (o_tdata),
    .o_tlast     (o_tlast),
    .o_tvalid    (o_tvalid),
    .o_tready    (o_tready),
    .detect      (detect),
    .frame_count (frame_count)
  );

  int checks   = 0;
  int failures = 0;

  logic [MW-1:0] metric_tab [0:255];
  int out_data[$];
  int tlast_cnt, tlast_val, det_cnt, det_at, notready_cnt, ready_bad, timed_out;
  int fc_exp;

  task automatic load_metrics(input int fill);
    for (int i = 0; i < 256; i++) metric_tab[i] = MW'(fill);
  endtask

  task automatic do_reset(input int nsym);
    reset       = 1'b1;
    clear       = 1'b0;
    threshold   = MW'(100);
    num_symbols = 8'(nsym);
    m_tdata     = '0;
    m_tlast     = 1'b0;
    m_tvalid    = 1'b0;
    s_tdata     = '0;
    s_tlast     = 1'b0;
    s_tvalid    = 1'b0;
    o_tready    = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Presents beats 0..n_beats-1 back to back and records what comes out.
  task automatic drive_stream(input int n_beats, input bit bp);
    int idx = 0;
    int cyc = 0;
    out_data.delete();
    tlast_cnt = 0; tlast_val = -1; det_cnt = 0; det_at = -1;
    notready_cnt = 0; ready_bad = 0; timed_out = 0;
    while (idx < n_beats) begin
      @(negedge clk);
      m_tvalid = 1'b1;
      s_tvalid = 1'b1;
      m_tdata  = metric_tab[idx];
      s_tdata  = 32'(idx);
      o_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (detect) begin det_cnt++; det_at = idx; end
      if (!m_tready) notready_cnt++;
      if (o_tvalid && !o_tready && m_tready) ready_bad++;
      if (m_tready !== s_tready) ready_bad++;
      if (o_tvalid && o_tready) begin
        out_data.push_back(int'(o_tdata));
        if (o_tlast) begin tlast_cnt++; tlast_val = int'(o_tdata); end
      end
      if (m_tready) idx++;
      cyc++;
      if (cyc > 4 * n_beats + 100) begin timed_out = 1; break; end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int seq_errors(input int first);
    int e = 0;
    foreach (out_data[i]) if (out_data[i] != first + i) e++;
    return e;
  endfunction

  function automatic int first_out();
    return (out_data.size() > 0) ? out_data[0] : -1;
  endfunction

  task automatic test_reset();
    do_reset(2);
    #1;
    checks++; if (o_tvalid !== 1'b0) begin failures++; $display("FAIL reset_o_tvalid: got %b expected 0", o_tvalid); end
    checks++; if (o_tlast !== 1'b0) begin failures++; $display("FAIL reset_o_tlast: got %b expected 0", o_tlast); end
    checks++; if (detect !== 1'b0) begin failures++; $display("FAIL reset_detect: got %b expected 0", detect); end
    checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
    checks++; if (m_tready !== 1'b1) begin failures++; $display("FAIL reset_m_tready: got %b expected 1", m_tready); end
  endtask

  task automatic test_single_peak();
    do_reset(2);
    load_metrics(0);
    metric_tab[10] = MW'(150);
    metric_tab[12] = MW'(300);
    drive_stream(100, 1'b0);
    m_tvalid = 1'b0; s_tvalid = 1'b0;
    checks++; if (timed_out !== 0) begin failures++; $display("FAIL single_timeout: got %0d expected 0", timed_out); end
    checks++; if (det_cnt !== 1) begin failures++; $display("FAIL single_detect_cnt: got %0d expected 1", det_cnt); end
    checks++; if (det_at !== 14) begin failures++; $display("FAIL single_detect_time: got beat %0d expected 14", det_at); end
    checks++; if (out_data.size() !== 40) begin failures++; $display("FAIL single_len: got %0d expected 40", out_data.size()); end
    checks++; if (first_out() !== 28) begin failures++; $display("FAIL single_first: got %0d expected 28", first_out()); end
    checks++; if (seq_errors(28) !== 0) begin failures++; $display("FAIL single_seq: got %0d bad samples expected 0", seq_errors(28)); end
    checks++; if (tlast_cnt !== 1) begin failures++; $display("FAIL single_tlast_cnt: got %0d expected 1", tlast_cnt); end
    checks++; if (tlast_val !== 67) begin failures++; $display("FAIL single_tlast_val: got %0d expected 67", tlast_val); end
    checks++; if (frame_count !== 16'(fc_exp)) begin failures++; $display("FAIL single_frame_count: got %0d expected %0d", frame_count, fc_exp); end
  endtask

  task automatic test_tie();
    do_reset(2);
    load_metrics(0);
    metric_tab[10] = MW'(200);
    metric_tab[11] = MW'(200);
    drive_stream(100, 1'b0);
    m_tvalid = 1'b0; s_tvalid = 1'b0;
    checks++; if (first_out() !== 26) begin failures++; $display("FAIL tie_first: got %0d expected 26", first_out()); end
    checks++; if (out_data.size() !== 40) begin failures++; $display("FAIL tie_len: got %0d expected 40", out_data.size()); end
    checks++; if (tlast_val !== 65) begin failures++; $display("FAIL tie_tlast_val: got %0d expected 65", tlast_val); end
  endtask

  task automatic test_backpressure();
    do_reset(2);
    load_metrics(0);
    metric_tab[10] = MW'(150);
    metric_tab[12] = MW'(300);
    drive_stream(100, 1'b1);
    m_tvalid = 1'b0; s_tvalid = 1'b0; o_tready = 1'b1;
    checks++; if (timed_out !== 0) begin failures++; $display("FAIL bp_timeout: got %0d expected 0", timed_out); end
    checks++; if (det_at !== 14) begin failures++; $display("FAIL bp_detect_time: got beat %0d expected 14", det_at); end
    checks++; if (out_data.size() !== 40) begin failures++; $display("FAIL bp_len: got %0d expected 40", out_data.size()); end
    checks++; if (seq_errors(28) !== 0) begin failures++; $display("FAIL bp_seq: got %0d bad samples expected 0", seq_errors(28)); end
    checks++; if (tlast_val !== 67) begin failures++; $display("FAIL bp_tlast_val: got %0d expected 67", tlast_val); end
    checks++; if (ready_bad !== 0) begin failures++; $display("FAIL bp_ready: got %0d violations expected 0", ready_bad); end
  endtask

  task automatic test_below_threshold();
    do_reset(2);
    load_metrics(100);
    drive_stream(60, 1'b1);
    m_tvalid = 1'b0; s_tvalid = 1'b0; o_tready = 1'b1;
    checks++; if (det_cnt !== 0) begin failures++; $display("FAIL below_detect: got %0d expected 0", det_cnt); end
    checks++; if (out_data.size() !== 0) begin failures++; $display("FAIL below_out: got %0d expected 0", out_data.size()); end
    checks++; if (notready_cnt !== 0) begin failures++; $display("FAIL below_ready: got %0d stalls expected 0", notready_cnt); end
  endtask

  task automatic test_zero_symbols();
    do_reset(0);
    load_metrics(0);
    metric_tab[10] = MW'(150);
    metric_tab[12] = MW'(300);
    drive_stream(80, 1'b0);
    m_tvalid = 1'b0; s_tvalid = 1'b0;
    checks++; if (out_data.size() !== 20) begin failures++; $display("FAIL nsym0_len: got %0d expected 20", out_data.size()); end
    checks++; if (tlast_val !== 47) begin failures++; $display("FAIL nsym0_tlast_val: got %0d expected 47", tlast_val); end
    checks++; if (frame_count !== 16'(fc_exp)) begin failures++; $display("FAIL nsym0_frame_count: got %0d expected %0d", frame_count, fc_exp); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset(2);
    load_metrics(0);
    metric_tab[10] = MW'(150);
    metric_tab[12] = MW'(300);
    drive_stream(33, 1'b0);
    checks++; if (out_data.size() !== 5) begin failures++; $display("FAIL midrst_pre_len: got %0d expected 5", out_data.size()); end
    m_tdata = '0;
    s_tdata = 32'd33;
    #1;
    checks++; if (o_tvalid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid: got %b expected 1", o_tvalid); end
    reset = 1'b1;
    #1;
    checks++; if (o_tvalid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b expected 0", o_tvalid); end
    checks++; if (o_tlast !== 1'b0) begin failures++; $display("FAIL midrst_tlast: got %b expected 0", o_tlast); end
    #1;
    reset = 1'b0;
    m_tvalid = 1'b0; s_tvalid = 1'b0;
    drive_stream(100, 1'b0);
    m_tvalid = 1'b0; s_tvalid = 1'b0;
    checks++; if (out_data.size() !== 40) begin failures++; $display("FAIL midrst_post_len: got %0d expected 40", out_data.size()); end
    checks++; if (seq_errors(28) !== 0) begin failures++; $display("FAIL midrst_post_seq: got %0d bad samples expected 0", seq_errors(28)); end
    checks++; if (tlast_val !== 67) begin failures++; $display("FAIL midrst_post_tlast: got %0d expected 67", tlast_val); end
  endtask

  initial begin
`ifdef SCHMIDL_COX_FRAME_COUNT_EN
    fc_exp = 1;
`else
    fc_exp = 0;
`endif
    test_reset();
    test_single_peak();
    test_tie();
    test_backpressure();
    test_below_threshold();
    test_zero_symbols();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
